// File: rtl/sd_spi_cmd_receiver.sv
// sd_spi_cmd_receiver: SD-card SPI command receiver.
// Oversamples SPI_CLK on the system clock, deframes SD command frames
// (start, transmit, index, argument, CRC7, stop), tracks the application
// command flag and shifts a host-supplied R1 byte out on DO.
// Optional feature: define SPI_CRC7_CHECK_EN to check CRC7 over the header.
// Requires CMD_W >= 2, ARG_W >= 2, SYNC_STAGES >= 2.
module sd_spi_cmd_receiver #(
  parameter int CMD_W         = 6,
  parameter int ARG_W         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int LSB_FIRST     = 1,
  parameter int APP_CMD_INDEX = 55
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_SPI_CLK,
  input  logic             io_SPI_CS,
  input  logic             io_SPI_DI,
  output logic             io_SPI_DO,
  input  logic [7:0]       io_RespData,
  input  logic             io_RespValid,
  output logic             io_RespReady,
  output logic             io_CmdValid,
  output logic [CMD_W-1:0] io_CmdIndex,
  output logic [ARG_W-1:0] io_CmdArg,
  output logic             io_CmdIsApp,
  output logic             io_CmdCrcOk,
  output logic             io_FrameError,
  output logic [2:0]       io_State
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CMD  = 3'd2,
    S_ARG  = 3'd3,
    S_CRC  = 3'd4,
    S_STOP = 3'd5,
    S_RESP = 3'd6
  } state_t;

  localparam logic [5:0] CMD_LAST  = 6'(CMD_W - 1);
  localparam logic [5:0] ARG_LAST  = 6'(ARG_W - 1);
  localparam logic [5:0] CRC_LAST  = 6'd6;
  localparam logic [5:0] RESP_BITS = 6'd8;

  state_t state, state_next;
  logic [5:0] cnt, cnt_next;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, di_sync;
  logic sclk_q;
  logic sclk_s, cs_s, di_s, rise, fall;

  logic [CMD_W-1:0] idx_sr;
  logic [ARG_W-1:0] arg_sr;
  logic [7:0]       resp_sr;
  logic             resp_loaded;
  logic             app_flag;
  logic             crc_ok;

  logic shift_idx, shift_arg, shift_crc, shift_hdr;
  logic cmd_done, frame_err, resp_load, resp_shift, do_next;

  // Synchronise the asynchronous SPI pins; CS resets to deselected.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= '0;
      cs_sync  <= '1;
      di_sync  <= '0;
      sclk_q   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], io_SPI_CLK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], io_SPI_CS};
      di_sync  <= {di_sync[SYNC_STAGES-2:0], io_SPI_DI};
      sclk_q   <= sclk_s;
    end
  end

  assign sclk_s = clk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign di_s   = di_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_q;
  assign fall   = ~sclk_s & sclk_q;

  // State and bit counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and datapath strobes; CS abort overrides everything.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_idx  = 1'b0;
    shift_arg  = 1'b0;
    shift_crc  = 1'b0;
    shift_hdr  = 1'b0;
    cmd_done   = 1'b0;
    frame_err  = 1'b0;
    resp_load  = 1'b0;
    resp_shift = 1'b0;
    do_next    = io_SPI_DO;
    if (cs_s) begin
      state_next = S_IDLE;
      do_next    = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (rise && !di_s) state_next = S_HDR;
        S_HDR: if (rise) begin
          shift_hdr = 1'b1;
          if (di_s) state_next = S_CMD;
          else begin
            frame_err  = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_CMD: if (rise) begin
          shift_idx = 1'b1;
          shift_hdr = 1'b1;
          cnt_next  = cnt + 6'd1;
          if (cnt == CMD_LAST) state_next = S_ARG;
        end
        S_ARG: if (rise) begin
          shift_arg = 1'b1;
          shift_hdr = 1'b1;
          cnt_next  = cnt + 6'd1;
          if (cnt == ARG_LAST) state_next = S_CRC;
        end
        S_CRC: if (rise) begin
          shift_crc = 1'b1;
          cnt_next  = cnt + 6'd1;
          if (cnt == CRC_LAST) state_next = S_STOP;
        end
        S_STOP: if (rise) begin
          if (di_s) begin
            cmd_done   = 1'b1;
            state_next = S_RESP;
          end else begin
            frame_err  = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_RESP: begin
          if (!resp_loaded) begin
            // An offered handshake is honoured before a new start bit.
            if (io_RespValid) resp_load = 1'b1;
            else if (rise && !di_s) state_next = S_HDR;
          end else if (fall && cnt < RESP_BITS) begin
            do_next    = resp_sr[7];
            resp_shift = 1'b1;
            cnt_next   = cnt + 6'd1;
          end else if (rise && cnt == RESP_BITS) begin
            // Host has sampled the last bit; release DO.
            do_next    = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    if (state_next != state) cnt_next = '0;
  end

  // Index / argument shift registers; bit placement set by LSB_FIRST.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_sr <= '0;
      arg_sr <= '0;
    end else begin
      if (shift_idx)
        idx_sr <= (LSB_FIRST != 0) ? {di_s, idx_sr[CMD_W-1:1]} : {idx_sr[CMD_W-2:0], di_s};
      if (shift_arg)
        arg_sr <= (LSB_FIRST != 0) ? {di_s, arg_sr[ARG_W-1:1]} : {arg_sr[ARG_W-2:0], di_s};
    end
  end

`ifdef SPI_CRC7_CHECK_EN
  logic [6:0] crc_rx, crc_calc;

  // Serial CRC7 (x^7+x^3+1) over the header in wire order; the start bit
  // is zero so clearing on entry to HDR already accounts for it.
  always_ff @(posedge clock) begin
    if (reset) begin
      crc_rx   <= '0;
      crc_calc <= '0;
    end else begin
      if (state != S_HDR && state_next == S_HDR)
        crc_calc <= '0;
      else if (shift_hdr)
        crc_calc <= {crc_calc[5:3], crc_calc[2] ^ (crc_calc[6] ^ di_s),
                     crc_calc[1:0], crc_calc[6] ^ di_s};
      if (shift_crc) crc_rx <= {crc_rx[5:0], di_s};
    end
  end

  assign crc_ok = (crc_rx == crc_calc);
`else
  assign crc_ok = 1'b1;
`endif

  // Response byte: load on handshake, shift MSB first on falls.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_sr     <= '0;
      resp_loaded <= 1'b0;
    end else begin
      if (resp_load) resp_sr <= io_RespData;
      else if (resp_shift) resp_sr <= {resp_sr[6:0], 1'b0};
      if (state_next != S_RESP) resp_loaded <= 1'b0;
      else if (resp_load) resp_loaded <= 1'b1;
    end
  end

  // Registered outputs and the application-command flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_SPI_DO     <= 1'b1;
      io_CmdValid   <= 1'b0;
      io_FrameError <= 1'b0;
      io_CmdIndex   <= '0;
      io_CmdArg     <= '0;
      io_CmdIsApp   <= 1'b0;
      io_CmdCrcOk   <= 1'b0;
      app_flag      <= 1'b0;
    end else begin
      io_SPI_DO     <= do_next;
      io_CmdValid   <= cmd_done;
      io_FrameError <= frame_err;
      if (cmd_done) begin
        io_CmdIndex <= idx_sr;
        io_CmdArg   <= arg_sr;
        io_CmdIsApp <= app_flag;
        io_CmdCrcOk <= crc_ok;
        app_flag    <= crc_ok && (idx_sr == CMD_W'(APP_CMD_INDEX));
      end
    end
  end

  assign io_RespReady = (state == S_RESP) && !resp_loaded && !cs_s;
  assign io_State     = state;

endmodule

// File: tb/tb_sd_spi_cmd_receiver.sv
// Bench for sd_spi_cmd_receiver: directed frame table, hand-written corner
// sequences (transmit-bit error, CS abort, R1 response) and random frames
// checked against a frame-level reference model.
module tb_sd_spi_cmd_receiver;
`ifdef SPI_CRC7_CHECK_EN
  localparam int LSBF   = 0;
  localparam bit CRC_EN = 1'b1;
`else
  localparam int LSBF   = 1;
  localparam bit CRC_EN = 1'b0;
`endif
  localparam int SYNC = 2;

  logic clock = 1'b0, reset = 1'b1;
  logic spi_clk = 1'b0, spi_cs = 1'b0, spi_di = 1'b1;
  logic [7:0] resp_data = 8'h00;
  logic resp_valid = 1'b0;
  logic spi_do, resp_ready, cmd_valid, cmd_is_app, cmd_crc_ok, frame_error;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic [2:0] state;

  always #5 clock = ~clock;

  sd_spi_cmd_receiver #(.CMD_W(6), .ARG_W(32), .SYNC_STAGES(SYNC),
                        .LSB_FIRST(LSBF), .APP_CMD_INDEX(55)) dut (
    .clock(clock), .reset(reset), .io_SPI_CLK(spi_clk), .io_SPI_CS(spi_cs),
    .io_SPI_DI(spi_di), .io_SPI_DO(spi_do), .io_RespData(resp_data),
    .io_RespValid(resp_valid), .io_RespReady(resp_ready),
    .io_CmdValid(cmd_valid), .io_CmdIndex(cmd_index), .io_CmdArg(cmd_arg),
    .io_CmdIsApp(cmd_is_app), .io_CmdCrcOk(cmd_crc_ok),
    .io_FrameError(frame_error), .io_State(state));

  int n_pass = 0, n_total = 0;
  int n_valid = 0, n_ferr = 0;
  logic [5:0] cap_idx;
  logic [31:0] cap_arg;
  logic cap_app, cap_crc;
  bit model_app = 1'b0;

  // Pulse monitor, sampled on the falling system clock.
  always @(negedge clock) begin
    if (!reset) begin
      if (cmd_valid) begin
        n_valid++;
        cap_idx = cmd_index;
        cap_arg = cmd_arg;
        cap_app = cmd_is_app;
        cap_crc = cmd_crc_ok;
      end
      if (frame_error) n_ferr++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One SPI mode-0 bit: DI changes with the falling edge, DO sampled before the rise.
  task automatic spi_bit(input logic b, output logic do_s);
    @(negedge clock);
    spi_clk = 1'b0;
    spi_di  = b;
    repeat (4) @(negedge clock);
    do_s = spi_do;
    spi_clk = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // 40 header bits in wire order (bit 39 goes first).
  function automatic logic [39:0] wire_hdr(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] w;
    w[39] = 1'b0;
    w[38] = 1'b1;
    for (int k = 0; k < 6; k++)  w[37-k] = (LSBF != 0) ? idx[k] : idx[5-k];
    for (int k = 0; k < 32; k++) w[31-k] = (LSBF != 0) ? arg[k] : arg[31-k];
    return w;
  endfunction

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [6:0] crc, input logic stop,
                            output int dv, output int df);
    logic [39:0] w;
    logic d;
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    w = wire_hdr(idx, arg);
    for (int i = 39; i >= 0; i--) spi_bit(w[i], d);
    for (int i = 6; i >= 0; i--) spi_bit(crc[i], d);
    spi_bit(stop, d);
    repeat (2) @(negedge clock);
    dv = n_valid - v0;
    df = n_ferr - f0;
  endtask

  // Frame checked against the reference model (app flag + CRC rule).
  task automatic run_checked(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [6:0] crc, input logic stop);
    int dv, df;
    bit ok_crc;
    ok_crc = CRC_EN ? (crc == crc7_ref(wire_hdr(idx, arg))) : 1'b1;
    send_frame(idx, arg, crc, stop, dv, df);
    if (stop) begin
      chk("m_valid_cnt", dv, 1);
      chk("m_ferr_cnt", df, 0);
      chk("m_index", cap_idx, idx);
      chk("m_arg", cap_arg, arg);
      chk("m_is_app", cap_app, model_app);
      chk("m_crc_ok", cap_crc, ok_crc);
      chk("m_state_resp", state, 6);
      chk("m_resp_ready", resp_ready, 1);
      model_app = ok_crc && (idx == 6'd55);
    end else begin
      chk("m_valid_cnt_bad", dv, 0);
      chk("m_ferr_cnt_bad", df, 1);
      chk("m_state_idle", state, 0);
    end
  endtask

  task automatic do_response(input logic [7:0] b);
    int waited;
    logic d;
    waited = 0;
    while (!resp_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk("resp_ready_wait", resp_ready, 1);
    resp_data  = b;
    resp_valid = 1'b1;
    @(negedge clock);
    resp_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      spi_bit(1'b1, d);
      chk($sformatf("do_bit%0d", i), d, b[7-i]);
    end
    chk("do_after_resp", spi_do, 1);
    chk("state_after_resp", state, 0);
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        auto_crc;
    logic [6:0]  crc;
    logic        stop;
    logic        exp_valid;
    logic [31:0] exp_arg;
    logic        exp_app;
    logic        exp_crc;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg,
                              input logic auto_crc, input logic [6:0] crc,
                              input logic stop, input logic ev, input logic ea,
                              input logic ec);
    vec_t v;
    v.idx = idx; v.arg = arg; v.auto_crc = auto_crc; v.crc = crc; v.stop = stop;
    v.exp_valid = ev; v.exp_arg = arg; v.exp_app = ea; v.exp_crc = ec;
    return v;
  endfunction

  initial begin
    vec_t tbl[11];
    int dv, df, v0, f0;
    logic d;
    logic [6:0] crc;

    tbl[0]  = mk(6'd0,  32'd1218,      1, 7'h00, 1, 1, 0, 1);
    tbl[1]  = mk(6'd55, 32'hDEADBEEF,  1, 7'h00, 1, 1, 0, 1);
    tbl[2]  = mk(6'd41, 32'h12345678,  1, 7'h00, 1, 1, 1, 1);
    tbl[3]  = mk(6'd16, 32'hFFFFFFFF,  1, 7'h00, 1, 1, 0, 1);
    tbl[4]  = mk(6'd55, 32'h00000000,  1, 7'h00, 0, 0, 0, 0);
    tbl[5]  = mk(6'd7,  32'h80000001,  1, 7'h00, 1, 1, 0, 1);
    tbl[6]  = mk(6'd55, 32'h00000001,  1, 7'h00, 1, 1, 0, 1);
    tbl[7]  = mk(6'd55, 32'h00000000,  1, 7'h00, 1, 1, 1, 1);
    tbl[8]  = mk(6'd0,  32'h00000000,  0, 7'h4A, 1, 1, 1, 1);
    tbl[9]  = mk(6'd55, 32'h00000000,  0, 7'h00, 1, 1, 0, !CRC_EN);
    tbl[10] = mk(6'd63, 32'h0F0F0F0F,  1, 7'h00, 1, 1, !CRC_EN, 1);

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_do", spi_do, 1);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_index", cmd_index, 0);
    chk("rst_arg", cmd_arg, 0);
    chk("rst_app", cmd_is_app, 0);
    chk("rst_crc", cmd_crc_ok, 0);
    chk("rst_ready", resp_ready, 0);
    chk("rst_state", state, 0);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // Directed table
    for (int t = 0; t < 11; t++) begin
      crc = tbl[t].auto_crc ? crc7_ref(wire_hdr(tbl[t].idx, tbl[t].arg)) : tbl[t].crc;
      send_frame(tbl[t].idx, tbl[t].arg, crc, tbl[t].stop, dv, df);
      chk($sformatf("t%0d_valid", t), dv, tbl[t].exp_valid ? 1 : 0);
      chk($sformatf("t%0d_ferr", t), df, tbl[t].exp_valid ? 0 : 1);
      chk($sformatf("t%0d_state", t), state, tbl[t].exp_valid ? 6 : 0);
      if (tbl[t].exp_valid) begin
        chk($sformatf("t%0d_index", t), cap_idx, tbl[t].idx);
        chk($sformatf("t%0d_arg", t), cap_arg, tbl[t].exp_arg);
        chk($sformatf("t%0d_app", t), cap_app, tbl[t].exp_app);
        chk($sformatf("t%0d_crc", t), cap_crc, tbl[t].exp_crc);
        model_app = tbl[t].exp_crc && (tbl[t].idx == 6'd55);
      end
    end

    // Bad transmit bit
    v0 = n_valid; f0 = n_ferr;
    spi_bit(1'b0, d);
    spi_bit(1'b0, d);
    repeat (2) @(negedge clock);
    chk("tx_err_ferr", n_ferr - f0, 1);
    chk("tx_err_valid", n_valid - v0, 0);
    chk("tx_err_state", state, 0);
    run_checked(6'd17, 32'hA5A5_0001, crc7_ref(wire_hdr(6'd17, 32'hA5A5_0001)), 1'b1);

    // CS abort after 10 argument bits
    begin
      logic [39:0] w;
      w = wire_hdr(6'd24, 32'h0000_3FF0);
      v0 = n_valid; f0 = n_ferr;
      for (int i = 39; i >= 22; i--) spi_bit(w[i], d);
      spi_cs = 1'b1;
      repeat (SYNC + 2) @(negedge clock);
      chk("abort_state", state, 0);
      chk("abort_do", spi_do, 1);
      repeat (4) @(negedge clock);
      chk("abort_no_valid", n_valid - v0, 0);
      chk("abort_no_ferr", n_ferr - f0, 0);
      spi_cs = 1'b0;
      repeat (4) @(negedge clock);
      run_checked(6'd24, 32'h0000_3FF0, crc7_ref(w), 1'b1);
    end

    // R1 response, then RespValid outside RESP is ignored
    do_response(8'h01);
    resp_data  = 8'h00;
    resp_valid = 1'b1;
    repeat (3) @(negedge clock);
    resp_valid = 1'b0;
    chk("idle_resp_ready", resp_ready, 0);
    chk("idle_resp_do", spi_do, 1);
    chk("idle_resp_state", state, 0);

    // Random frames against the model
    for (int r = 0; r < 40; r++) begin
      logic [5:0] idx;
      logic [31:0] arg;
      logic stop;
      idx  = ($urandom_range(0, 3) == 0) ? 6'd55 : 6'($urandom_range(0, 63));
      arg  = $urandom;
      stop = ($urandom_range(0, 7) != 0);
      crc  = crc7_ref(wire_hdr(idx, arg));
      if ($urandom_range(0, 3) == 0) crc = crc ^ 7'($urandom_range(1, 127));
      run_checked(idx, arg, crc, stop);
      if (stop && $urandom_range(0, 1) == 1) do_response(8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
